// File: rtl/lsu_ram_rsp_pkg.sv
// Shared configuration for the LSU RAM responder: responder FSM states and latency range.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif

package lsu_ram_rsp_pkg;

    localparam int LAT_MIN = 1;
    localparam int LAT_MAX = 7;
    localparam int CNT_W   = $clog2(LAT_MAX + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } ram_rsp_state_e;

endpackage

// File: rtl/lsu_ram_rsp_array.sv
// Word storage with per-byte masked synchronous write and asynchronous read; contents are never reset.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif

module ram_mask_array #(
    parameter int DEPTH      = 1024,
    parameter int DATA_WIDTH = `DATA_WIDTH,
    parameter int BYTE_WIDTH = `BYTE_WIDTH,
    parameter int IDX_W      = $clog2(DEPTH),
    parameter int NBYTES     = DATA_WIDTH / BYTE_WIDTH
) (
    input  logic                  i_clk,
    input  logic                  i_wr_en,
    input  logic [IDX_W-1:0]      i_wr_idx,
    input  logic [DATA_WIDTH-1:0] i_wr_data,
    input  logic [NBYTES-1:0]     i_wr_mask,
    input  logic [IDX_W-1:0]      i_rd_idx,
    output logic [DATA_WIDTH-1:0] o_rd_data
);

    logic [DATA_WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_wr_en) begin
            for (int b = 0; b < NBYTES; b++) begin
                if (i_wr_mask[b]) begin
                    r_mem[i_wr_idx][b*BYTE_WIDTH +: BYTE_WIDTH] <= i_wr_data[b*BYTE_WIDTH +: BYTE_WIDTH];
                end
            end
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/lsu_ram_rsp.sv
// LSU data-memory responder: single-cycle masked writes, reads answered after LATENCY cycles.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif

module lsu_ram_rsp
    import lsu_ram_rsp_pkg::*;
#(
    parameter int DEPTH    = 1024,
    parameter int LATENCY  = 2,
    parameter int OFF_BITS = $clog2(`DATA_WIDTH/8)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_lsu_ram_rd_en,
    input  logic [`ADDR_WIDTH-1:0]   i_lsu_ram_rd_addr,
    input  logic                     i_lsu_ram_wr_en,
    input  logic [`ADDR_WIDTH-1:0]   i_lsu_ram_wr_addr,
    input  logic [`DATA_WIDTH-1:0]   i_lsu_ram_wr_data,
    input  logic [`DATA_WIDTH/8-1:0] i_lsu_ram_wr_mask,
    output logic                     o_ram_ready,
    output logic                     o_ram_rd_valid,
    output logic [`DATA_WIDTH-1:0]   o_ram_rd_data,
    output logic                     o_ram_misalign
);

    localparam int IDX_W = $clog2(DEPTH);

    ram_rsp_state_e         r_state;
    ram_rsp_state_e         w_next_state;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_next_cnt;
    logic [IDX_W-1:0]       r_rd_idx;
    logic                   r_ready;
    logic                   r_misalign;
    logic [`DATA_WIDTH-1:0] r_rd_hold;
    logic [`DATA_WIDTH-1:0] w_rd_word;

    logic                   w_accept;
    logic                   w_rd_accept;
    logic                   w_wr_commit;
    logic                   w_misalign;
    logic [IDX_W-1:0]       w_rd_idx_in;
    logic [IDX_W-1:0]       w_wr_idx_in;
    logic                   w_unused_addr;

    assign w_accept    = r_ready & (i_lsu_ram_rd_en | i_lsu_ram_wr_en);
    assign w_rd_accept = w_accept & i_lsu_ram_rd_en;
    assign w_wr_commit = w_accept & i_lsu_ram_wr_en;

    // Upper address bits fall away here, so out-of-range addresses wrap onto the array.
    assign w_rd_idx_in = i_lsu_ram_rd_addr[OFF_BITS +: IDX_W];
    assign w_wr_idx_in = i_lsu_ram_wr_addr[OFF_BITS +: IDX_W];
    assign w_misalign  = w_accept &
                         ((i_lsu_ram_rd_en & (|i_lsu_ram_rd_addr[OFF_BITS-1:0])) |
                          (i_lsu_ram_wr_en & (|i_lsu_ram_wr_addr[OFF_BITS-1:0])));
    assign w_unused_addr = ^{i_lsu_ram_rd_addr, i_lsu_ram_wr_addr};

    ram_mask_array #(
        .DEPTH      (DEPTH),
        .DATA_WIDTH (`DATA_WIDTH),
        .BYTE_WIDTH (`BYTE_WIDTH)
    ) u_array (
        .i_clk     (i_clk),
        .i_wr_en   (w_wr_commit),
        .i_wr_idx  (w_wr_idx_in),
        .i_wr_data (i_lsu_ram_wr_data),
        .i_wr_mask (i_lsu_ram_wr_mask),
        .i_rd_idx  (r_rd_idx),
        .o_rd_data (w_rd_word)
    );

    always_comb begin
        w_next_state = r_state;
        w_next_cnt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_rd_accept) begin
                    if (LATENCY == 1) begin
                        w_next_state = RESP;
                        w_next_cnt   = '0;
                    end else begin
                        w_next_state = BUSY;
                        w_next_cnt   = CNT_W'(LATENCY - 1);
                    end
                end
            end
            BUSY: begin
                if (r_cnt == CNT_W'(1)) begin
                    w_next_state = RESP;
                    w_next_cnt   = '0;
                end else begin
                    w_next_cnt = r_cnt - CNT_W'(1);
                end
            end
            RESP: begin
                w_next_state = IDLE;
            end
            default: begin
                w_next_state = IDLE;
                w_next_cnt   = '0;
            end
        endcase
    end

    // Ready is registered so it stays low for the first cycle after reset release.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_ready    <= 1'b0;
            r_misalign <= 1'b0;
            r_rd_idx   <= '0;
            r_rd_hold  <= '0;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_next_cnt;
            r_ready    <= (w_next_state == IDLE);
            r_misalign <= w_misalign;
            if (w_rd_accept) begin
                r_rd_idx <= w_rd_idx_in;
            end
            if (r_state == RESP) begin
                r_rd_hold <= w_rd_word;
            end
        end
    end

    assign o_ram_ready    = r_ready;
    assign o_ram_rd_valid = (r_state == RESP);
    assign o_ram_rd_data  = (r_state == RESP) ? w_rd_word : r_rd_hold;
    assign o_ram_misalign = r_misalign;

endmodule

// File: tb/tb_lsu_ram_rsp.sv
// Directed self-checking bench for lsu_ram_rsp with LATENCY = 2 and DEPTH = 1024.
`ifndef DATA_WIDTH
`define DATA_WIDTH 64
`endif
`ifndef ADDR_WIDTH
`define ADDR_WIDTH 32
`endif
`ifndef BYTE_WIDTH
`define BYTE_WIDTH 8
`endif

module tb_lsu_ram_rsp;

    logic                     clk;
    logic                     rstN;
    logic                     rdEn;
    logic [`ADDR_WIDTH-1:0]   rdAddr;
    logic                     wrEn;
    logic [`ADDR_WIDTH-1:0]   wrAddr;
    logic [`DATA_WIDTH-1:0]   wrData;
    logic [`DATA_WIDTH/8-1:0] wrMask;
    logic                     ramReady;
    logic                     rdValid;
    logic [`DATA_WIDTH-1:0]   rdData;
    logic                     misalign;

    int checkCount = 0;
    int failCount  = 0;

    lsu_ram_rsp #(
        .DEPTH   (1024),
        .LATENCY (2)
    ) dut (
        .i_clk             (clk),
        .i_rst_n           (rstN),
        .i_lsu_ram_rd_en   (rdEn),
        .i_lsu_ram_rd_addr (rdAddr),
        .i_lsu_ram_wr_en   (wrEn),
        .i_lsu_ram_wr_addr (wrAddr),
        .i_lsu_ram_wr_data (wrData),
        .i_lsu_ram_wr_mask (wrMask),
        .o_ram_ready       (ramReady),
        .o_ram_rd_valid    (rdValid),
        .o_ram_rd_data     (rdData),
        .o_ram_misalign    (misalign)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        checkCount++;
        if (observed !== expected) begin
            failCount++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    task automatic idleInputs();
        rdEn   = 1'b0;
        rdAddr = '0;
        wrEn   = 1'b0;
        wrAddr = '0;
        wrData = '0;
        wrMask = '0;
    endtask

    // One write, checking that ready never drops for it.
    task automatic applyStimulus(input logic [31:0] addr, input logic [63:0] data, input logic [7:0] mask);
        @(negedge clk);
        wrEn   = 1'b1;
        wrAddr = addr;
        wrData = data;
        wrMask = mask;
        @(posedge clk);
        @(negedge clk);
        idleInputs();
        checkOutput("wr_ready_kept", 64'(ramReady), 64'd1);
    endtask

    // Read (optionally with a simultaneous write) and check the whole LATENCY=2 response timeline.
    task automatic readCheck(input string tag, input logic [31:0] addr, input logic withWr,
                             input logic [63:0] wData, input logic [7:0] wMask,
                             input logic [63:0] expData, input logic expMis);
        @(negedge clk);
        rdEn   = 1'b1;
        rdAddr = addr;
        wrEn   = withWr;
        wrAddr = addr;
        wrData = wData;
        wrMask = wMask;
        @(posedge clk);
        @(negedge clk);
        idleInputs();
        checkOutput({tag, "_c1_ready"}, 64'(ramReady), 64'd0);
        checkOutput({tag, "_c1_valid"}, 64'(rdValid), 64'd0);
        checkOutput({tag, "_c1_mis"}, 64'(misalign), 64'(expMis));
        @(negedge clk);
        checkOutput({tag, "_c2_ready"}, 64'(ramReady), 64'd0);
        checkOutput({tag, "_c2_valid"}, 64'(rdValid), 64'd1);
        checkOutput({tag, "_c2_data"}, rdData, expData);
        checkOutput({tag, "_c2_mis"}, 64'(misalign), 64'd0);
        @(negedge clk);
        checkOutput({tag, "_c3_ready"}, 64'(ramReady), 64'd1);
        checkOutput({tag, "_c3_valid"}, 64'(rdValid), 64'd0);
        checkOutput({tag, "_c3_hold"}, rdData, expData);
    endtask

    initial begin
        idleInputs();
        rstN = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checkOutput("rst_ready_low", 64'(ramReady), 64'd0);
        checkOutput("rst_valid", 64'(rdValid), 64'd0);
        rstN = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("idle_ready", 64'(ramReady), 64'd1);
        checkOutput("idle_valid", 64'(rdValid), 64'd0);
        checkOutput("idle_data", rdData, 64'd0);
        checkOutput("idle_mis", 64'(misalign), 64'd0);

        applyStimulus(32'h40, 64'h1122334455667788, 8'hFF);
        readCheck("full", 32'h40, 1'b0, '0, '0, 64'h1122334455667788, 1'b0);

        applyStimulus(32'h40, 64'h00000000000000AA, 8'h01);
        readCheck("mask01", 32'h40, 1'b0, '0, '0, 64'h11223344556677AA, 1'b0);

        applyStimulus(32'h40, 64'h000000000000BEEF, 8'h03);
        readCheck("mask03", 32'h40, 1'b0, '0, '0, 64'h112233445566BEEF, 1'b0);

        readCheck("rdwr", 32'h80, 1'b1, 64'h000000000000DEAD, 8'hFF, 64'h000000000000DEAD, 1'b0);

        readCheck("misal", 32'h43, 1'b0, '0, '0, 64'h112233445566BEEF, 1'b1);
        readCheck("wrap", 32'h2040, 1'b0, '0, '0, 64'h112233445566BEEF, 1'b0);

        // Reset while BUSY drops the read and clears the held data.
        @(negedge clk);
        rdEn   = 1'b1;
        rdAddr = 32'h80;
        @(posedge clk);
        @(negedge clk);
        idleInputs();
        rstN = 1'b0;
        #1;
        checkOutput("mid_rst_valid", 64'(rdValid), 64'd0);
        @(negedge clk);
        checkOutput("mid_rst_valid2", 64'(rdValid), 64'd0);
        rstN = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checkOutput("post_rst_ready", 64'(ramReady), 64'd1);
        checkOutput("post_rst_valid", 64'(rdValid), 64'd0);
        checkOutput("post_rst_data", rdData, 64'd0);

        // Write held high while ready is low must be ignored.
        @(negedge clk);
        rdEn   = 1'b1;
        rdAddr = 32'h40;
        @(posedge clk);
        @(negedge clk);
        rdEn   = 1'b0;
        wrEn   = 1'b1;
        wrAddr = 32'h40;
        wrData = 64'hFFFFFFFFFFFFFFFF;
        wrMask = 8'hFF;
        @(negedge clk);
        checkOutput("blk_valid", 64'(rdValid), 64'd1);
        checkOutput("blk_data", rdData, 64'h112233445566BEEF);
        idleInputs();
        @(negedge clk);
        checkOutput("blk_ready", 64'(ramReady), 64'd1);
        readCheck("blk_after", 32'h40, 1'b0, '0, '0, 64'h112233445566BEEF, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checkCount, failCount);
        $finish;
    end

endmodule
